// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the latency-modelling memory slave.
package mem_slave_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} mem_slv_state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Wide enough for MIN_LAT + 2**LAT_LOG2 - 1 with one bit of headroom.
   function automatic int lat_width(input int min_lat, input int lat_log2);
      return $clog2(min_lat + 2**lat_log2) + 1;
   endfunction

endpackage

// File: rtl/lfsr_delay_gen.sv
// Free-running 16-bit Fibonacci LFSR producing the per-transaction wait count.
module lfsr_delay_gen
   import mem_slave_pkg::*;
#(
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int          LAT_LOG2 = 3,
   parameter int          MIN_LAT  = 1,
   parameter int          RAND_EN  = 1,
   localparam int         LAT_W    = lat_width(MIN_LAT, LAT_LOG2)
)(
   input  logic             clk,
   input  logic             reset,
   output logic [LAT_W-1:0] delay
);

   logic [15:0] lfsr;
   logic        fb;

   assign fb = ^(lfsr & LFSR_TAPS);

   always_ff @(posedge clk) begin
      if (reset) lfsr <= SEED;
      else       lfsr <= {lfsr[14:0], fb};
   end

   generate
      if (RAND_EN != 0) begin : g_rand
         assign delay = LAT_W'(MIN_LAT) + LAT_W'(lfsr[LAT_LOG2-1:0]);
      end else begin : g_fixed
         assign delay = LAT_W'(MIN_LAT);
      end
   endgenerate

endmodule

// File: rtl/mem_slave_lat.sv
// Valid/ready memory slave with byte strobes, LFSR or fixed response latency
// and an error response for addresses beyond the implemented depth.
module mem_slave_lat
   import mem_slave_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          ADDR_W   = 4,
   parameter int          DEPTH    = 16,
   parameter int          RAND_EN  = 1,
   parameter int          MIN_LAT  = 1,
   parameter int          LAT_LOG2 = 3,
   parameter logic [15:0] SEED     = 16'hACE1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                req_i,
   input  logic                req_rnw_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [DATA_W/8-1:0] req_wstrb_i,
   output logic                req_ready_o,
   output logic [DATA_W-1:0]   req_rdata_o,
   output logic                req_err_o
);

   // state | meaning
   // IDLE  | waiting for req_i; captures the request and its delay
   // WAIT  | counting down the remaining wait cycles
   // ACK   | one-cycle completion pulse; write commits at its closing edge

   localparam int               LAT_W   = lat_width(MIN_LAT, LAT_LOG2);
   localparam int               NB      = DATA_W / 8;
   localparam logic [ADDR_W:0]  DEPTH_L = DEPTH[ADDR_W:0];

   mem_slv_state_e    state;
   logic [LAT_W-1:0]  cnt;
   logic [LAT_W-1:0]  delay;

   logic              cap_rnw;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_wdata;
   logic [NB-1:0]     cap_wstrb;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              idle_take;
   logic              go_ack;
   logic              ack_rnw;
   logic [ADDR_W-1:0] ack_addr;
   logic              ack_hit;
   logic              commit;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_L;
   endfunction

   lfsr_delay_gen #(
      .SEED     (SEED),
      .LAT_LOG2 (LAT_LOG2),
      .MIN_LAT  (MIN_LAT),
      .RAND_EN  (RAND_EN)
   ) u_delay (
      .clk   (clk),
      .reset (reset),
      .delay (delay)
   );

   // A zero delay enters ACK straight from IDLE, so the response is built
   // from the live request fields rather than the capture registers.
   assign idle_take = (state == IDLE) && req_i;
   assign go_ack    = (idle_take && (delay == '0)) || ((state == WAIT) && (cnt == '0));
   assign ack_rnw   = (state == IDLE) ? req_rnw_i  : cap_rnw;
   assign ack_addr  = (state == IDLE) ? req_addr_i : cap_addr;
   assign ack_hit   = in_range(ack_addr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         req_ready_o <= 1'b0;
         req_rdata_o <= '0;
         req_err_o   <= 1'b0;
      end else begin
         req_ready_o <= go_ack;
         req_rdata_o <= (go_ack && ack_rnw && ack_hit) ? mem[ack_addr] : '0;
         req_err_o   <= go_ack && !ack_hit;
         case (state)
            IDLE: begin
               if (idle_take) begin
                  if (delay == '0) begin
                     state <= ACK;
                  end else begin
                     cnt   <= delay - LAT_W'(1);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) state <= ACK;
               else           cnt   <= cnt - LAT_W'(1);
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (idle_take) begin
         cap_rnw   <= req_rnw_i;
         cap_addr  <= req_addr_i;
         cap_wdata <= req_wdata_i;
         cap_wstrb <= req_wstrb_i;
      end
   end

   // Reset on the closing edge of ACK drops the pending write.
   assign commit = !reset && (state == ACK) && !cap_rnw && in_range(cap_addr);

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (cap_wstrb[b]) mem[cap_addr][8*b +: 8] <= cap_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_slave_lat.sv
// Bench: a fixed-latency slave and a randomised-latency slave checked against
// a word-level memory model and an LFSR latency sequence computed up front.
module tb_mem_slave_lat;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_f, req_r;
   logic        rnw;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        rdy_f, err_f, rdy_r, err_r;
   logic [31:0] rd_f, rd_r;

   logic        sel;
   logic        rdy, err;
   logic [31:0] rd;

   int          k;
   logic [15:0] seq [0:16383];
   logic [31:0] mdl_f [0:15];
   logic [31:0] mdl_r [0:15];
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mem_slave_lat #(
      .DATA_W(32), .ADDR_W(4), .DEPTH(16), .RAND_EN(0), .MIN_LAT(3), .LAT_LOG2(3), .SEED(16'hACE1)
   ) u_fix (
      .clk(clk), .reset(reset), .req_i(req_f), .req_rnw_i(rnw), .req_addr_i(addr),
      .req_wdata_i(wdata), .req_wstrb_i(wstrb), .req_ready_o(rdy_f), .req_rdata_o(rd_f),
      .req_err_o(err_f)
   );

   mem_slave_lat #(
      .DATA_W(32), .ADDR_W(4), .DEPTH(12), .RAND_EN(1), .MIN_LAT(1), .LAT_LOG2(3), .SEED(16'hACE1)
   ) u_rnd (
      .clk(clk), .reset(reset), .req_i(req_r), .req_rnw_i(rnw), .req_addr_i(addr),
      .req_wdata_i(wdata), .req_wstrb_i(wstrb), .req_ready_o(rdy_r), .req_rdata_o(rd_r),
      .req_err_o(err_r)
   );

   assign rdy = sel ? rdy_r : rdy_f;
   assign rd  = sel ? rd_r  : rd_f;
   assign err = sel ? err_r : err_f;

   // Non-reset edges seen since the last reset edge; indexes the LFSR sequence.
   always @(posedge clk) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // x^16+x^14+x^13+x^11+1, shifting towards the MSB.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic txn(input bit s, input bit r, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] st, input bit scramble, input logic [31:0] exp_rd,
                      input bit exp_er, output int lat);
      int exp_lat;
      bit seen;
      exp_lat = s ? 2 + int'(seq[k][2:0]) : 4;
      sel = s; rnw = r; addr = a; wdata = d; wstrb = st;
      if (s) req_r = 1'b1; else req_f = 1'b1;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (rdy) begin
            seen = 1'b1;
         end else begin
            chk("rdata_idle", rd, 32'd0);
            chk("err_idle", 32'(err), 32'd0);
            if (scramble) begin
               rnw   = 1'($urandom_range(0, 1));
               addr  = 4'($urandom_range(0, 15));
               wdata = $urandom;
               wstrb = 4'($urandom_range(0, 15));
               if (s) req_r = 1'($urandom_range(0, 1));
               else   req_f = 1'($urandom_range(0, 1));
            end
         end
      end
      chk("ack_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), 32'(exp_lat));
      if (s) chk("lat_range", 32'(lat >= 2 && lat <= 9), 32'd1);
      chk("rdata", rd, exp_rd);
      chk("err", 32'(err), 32'(exp_er));
      @(posedge clk); #1;
      chk("one_pulse", 32'(rdy), 32'd0);
      chk("rdata_after", rd, 32'd0);
      req_f = 1'b0;
      req_r = 1'b0;
   endtask

   task automatic do_t(input bit s, input bit r, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] st, input bit scramble, output int lat);
      bit          hit;
      logic [31:0] old, exp_rd;
      hit    = s ? (a < 4'd12) : 1'b1;
      old    = s ? mdl_r[a] : mdl_f[a];
      exp_rd = (r && hit) ? old : 32'd0;
      txn(s, r, a, d, st, scramble, exp_rd, !hit, lat);
      if (!r && hit) begin
         if (s) mdl_r[a] = merge(old, d, st);
         else   mdl_f[a] = merge(old, d, st);
      end
   endtask

   initial begin
      int lat, lat_first, lat2;
      seq[0] = 16'hACE1;
      for (int i = 1; i < 16384; i++) seq[i] = lfsr_step(seq[i-1]);

      reset = 1'b1; req_f = 1'b0; req_r = 1'b0; sel = 1'b0;
      rnw = 1'b0; addr = '0; wdata = '0; wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_f", 32'(rdy_f), 32'd0);
      chk("rst_rdata_f", rd_f, 32'd0);
      chk("rst_err_f", 32'(err_f), 32'd0);
      chk("rst_ready_r", 32'(rdy_r), 32'd0);
      chk("rst_rdata_r", rd_r, 32'd0);
      chk("rst_err_r", 32'(err_r), 32'd0);
      reset = 1'b0;

      // First transaction after reset: SEED[2:0]=1 gives D=2, latency 3.
      do_t(1, 0, 4'd0, $urandom, 4'hF, 0, lat_first);
      chk("lat_first", 32'(lat_first), 32'd3);
      for (int a = 1; a < 12; a++) do_t(1, 0, 4'(a), $urandom, 4'hF, 0, lat);
      do_t(1, 0, 4'd13, 32'hDEADBEEF, 4'hF, 0, lat);
      do_t(1, 1, 4'd13, 32'd0, 4'h0, 0, lat);
      for (int a = 0; a < 12; a++) do_t(1, 1, 4'(a), 32'd0, 4'h0, 0, lat);

      do_t(0, 0, 4'd2, 32'hA5A5A5A5, 4'hF, 0, lat);
      do_t(0, 1, 4'd2, 32'd0, 4'h0, 0, lat);
      do_t(0, 0, 4'd2, 32'h11223344, 4'b0011, 0, lat);
      do_t(0, 1, 4'd2, 32'd0, 4'h0, 0, lat);
      do_t(0, 0, 4'd2, 32'hFFFFFFFF, 4'h0, 1, lat);
      do_t(0, 1, 4'd2, 32'd0, 4'h0, 1, lat);

      for (int n = 0; n < 500; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         repeat (gap) begin @(posedge clk); #1; end
         do_t(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)), 1, lat);
      end

      // Reset while the write to addr 5 sits in WAIT: it must never land.
      sel = 1'b1; rnw = 1'b0; addr = 4'd5; wdata = ~mdl_r[5]; wstrb = 4'hF; req_r = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1; req_r = 1'b0;
      @(posedge clk); #1;
      chk("rst_wait_ready", 32'(rdy_r), 32'd0);
      @(posedge clk); #1;
      chk("rst_wait_ready2", 32'(rdy_r), 32'd0);
      reset = 1'b0;
      do_t(1, 1, 4'd5, 32'd0, 4'h0, 0, lat2);
      chk("lat_repeat", 32'(lat2), 32'(lat_first));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
